// File: rtl/proc_hier_top.sv
// proc_hier_top: single-cycle 16-bit processor with a free-running cycle counter.
// One instruction is fetched per cycle from an external instruction port and
// executed combinationally. PC, register file and cycle counter update on the
// rising clock edge. Per-cycle commit signals are exposed for a trace monitor.
//
// Optional feature macro: PROC_ERR_EN. When it is defined, err flags undefined
// opcodes. When it is undefined, err is tied low.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   imem_addr    instruction byte address (= PC)
//   imem_data    instruction word for imem_addr (combinational)
//   mem_addr     data memory byte address (Rs + imm5 for LD/ST, else 0)
//   mem_wdata    store data (Rt for ST, else 0)
//   mem_rdata    load data for mem_addr (combinational)
//   mem_re       load in progress
//   mem_we       store commits at next rising edge
//   pc, inst     PC and instruction of the current cycle
//   reg_we       register write this cycle
//   reg_wsel     destination register (0 when reg_we=0)
//   reg_wdata    write data (0 when reg_we=0)
//   halt         HALT is the current instruction
//   cycle_count  edges since reset release, wraps at 2^32
//   err          undefined opcode
module proc_hier_top (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_re,
  output logic        mem_we,
  output logic [15:0] pc,
  output logic [15:0] inst,
  output logic        reg_we,
  output logic [2:0]  reg_wsel,
  output logic [15:0] reg_wdata,
  output logic        halt,
  output logic [31:0] cycle_count,
  output logic        err
);

  typedef enum logic [4:0] {
    OP_HALT = 5'b00000,
    OP_NOP  = 5'b00001,
    OP_J    = 5'b00100,
    OP_ADDI = 5'b01000,
    OP_BEQZ = 5'b01100,
    OP_BNEZ = 5'b01101,
    OP_ST   = 5'b10000,
    OP_LD   = 5'b10001,
    OP_LBI  = 5'b11000,
    OP_ALU  = 5'b11011
  } opcode_e;

  logic [15:0] r_pc;
  logic [15:0] r_regs [8];
  logic [31:0] r_cycle;

  opcode_e     w_op;
  logic [15:0] w_rs_val, w_rt_val;
  logic [15:0] w_imm5, w_imm8, w_disp11;
  logic [15:0] w_pc_inc, w_next_pc, w_ea;
  logic        w_we, w_mre, w_mwe, w_halt;
  logic [2:0]  w_wsel;
  logic [15:0] w_wdata, w_maddr, w_mwdata;
`ifdef PROC_ERR_EN
  logic        w_undef;
`endif

  assign w_op     = opcode_e'(imem_data[15:11]);
  assign w_rs_val = r_regs[imem_data[10:8]];
  assign w_rt_val = r_regs[imem_data[7:5]];
  assign w_imm5   = {{11{imem_data[4]}}, imem_data[4:0]};
  assign w_imm8   = {{8{imem_data[7]}}, imem_data[7:0]};
  assign w_disp11 = {{5{imem_data[10]}}, imem_data[10:0]};
  assign w_pc_inc = r_pc + 16'd2;
  assign w_ea     = w_rs_val + w_imm5;

  always_comb begin
    w_next_pc = w_pc_inc;
    w_we      = 1'b0;
    w_wsel    = '0;
    w_wdata   = '0;
    w_mre     = 1'b0;
    w_mwe     = 1'b0;
    w_maddr   = '0;
    w_mwdata  = '0;
    w_halt    = 1'b0;
`ifdef PROC_ERR_EN
    w_undef   = 1'b0;
`endif
    case (w_op)
      OP_HALT: begin
        w_halt    = 1'b1;
        w_next_pc = r_pc;
      end
      OP_NOP: ;
      OP_ADDI: begin
        w_we    = 1'b1;
        w_wsel  = imem_data[7:5];
        w_wdata = w_ea;
      end
      OP_ST: begin
        w_mwe    = 1'b1;
        w_maddr  = w_ea;
        w_mwdata = w_rt_val;
      end
      OP_LD: begin
        w_mre   = 1'b1;
        w_maddr = w_ea;
        w_we    = 1'b1;
        w_wsel  = imem_data[7:5];
        w_wdata = mem_rdata;
      end
      OP_ALU: begin
        w_we   = 1'b1;
        w_wsel = imem_data[4:2];
        case (imem_data[1:0])
          2'b00:   w_wdata = w_rs_val + w_rt_val;
          2'b01:   w_wdata = w_rs_val - w_rt_val;
          2'b10:   w_wdata = w_rs_val ^ w_rt_val;
          default: w_wdata = w_rs_val & ~w_rt_val;
        endcase
      end
      OP_LBI: begin
        w_we    = 1'b1;
        w_wsel  = imem_data[10:8];
        w_wdata = w_imm8;
      end
      OP_BEQZ: if (w_rs_val == 16'd0) w_next_pc = w_pc_inc + w_imm8;
      OP_BNEZ: if (w_rs_val != 16'd0) w_next_pc = w_pc_inc + w_imm8;
      OP_J:    w_next_pc = w_pc_inc + w_disp11;
      default: begin
`ifdef PROC_ERR_EN
        w_undef = 1'b1;
`endif
      end
    endcase
  end

  // Commit strobes are gated by rst so an asynchronous reset mid-cycle
  // cancels any pending write immediately, not just at the next edge.
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign inst        = imem_data;
  assign reg_we      = rst & w_we;
  assign reg_wsel    = reg_we ? w_wsel : 3'd0;
  assign reg_wdata   = reg_we ? w_wdata : 16'd0;
  assign mem_re      = rst & w_mre;
  assign mem_we      = rst & w_mwe;
  assign mem_addr    = w_maddr;
  assign mem_wdata   = w_mwdata;
  assign halt        = rst & w_halt;
  assign cycle_count = r_cycle;
`ifdef PROC_ERR_EN
  assign err         = rst & w_undef;
`else
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc    <= '0;
      r_cycle <= '0;
      for (int unsigned i = 0; i < 8; i++) r_regs[i] <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      r_pc    <= w_next_pc;
      if (w_we) r_regs[w_wsel] <= w_wdata;
    end
  end

endmodule

// File: tb/tb_proc_hier_top.sv
`timescale 1ns/1ps
module tb_proc_hier_top;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] imem_addr, imem_data, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] pc, inst, reg_wdata;
  logic        mem_re, mem_we, reg_we, halt, err;
  logic [2:0]  reg_wsel;
  logic [31:0] cycle_count;

  logic [15:0] imem [0:32767];
  logic [15:0] dmem [0:65535];

  int n_cmp = 0;
  int n_bad = 0;

  // reference state
  logic [15:0] m_pc;
  logic [15:0] m_r [8];
  logic [31:0] m_cycle;

  proc_hier_top dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_re(mem_re), .mem_we(mem_we),
    .pc(pc), .inst(inst),
    .reg_we(reg_we), .reg_wsel(reg_wsel), .reg_wdata(reg_wdata),
    .halt(halt), .cycle_count(cycle_count), .err(err)
  );

  always #5 clk = ~clk;

  assign imem_data = imem[imem_addr[15:1]];
  assign mem_rdata = dmem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h (model pc %h)", tag, obs, exp, m_pc);
    end
  endtask

  task automatic model_reset();
    m_pc    = '0;
    m_cycle = '0;
    for (int i = 0; i < 8; i++) m_r[i] = '0;
  endtask

  // Evaluate the current instruction from the architectural rules, compare
  // every trace output, then retire it into the reference state.
  task automatic check_cycle();
    logic [15:0] ins, a, b, s5, s8, s11, npc, wdat, ma, mwd;
    logic [2:0]  wsel;
    logic        we, re, st, hl, und, exp_err;
    ins = imem[m_pc[15:1]];
    a   = m_r[ins[10:8]];
    b   = m_r[ins[7:5]];
    s5  = {{11{ins[4]}}, ins[4:0]};
    s8  = {{8{ins[7]}}, ins[7:0]};
    s11 = {{5{ins[10]}}, ins[10:0]};
    npc = m_pc + 16'd2;
    we = 0; re = 0; st = 0; hl = 0; und = 0;
    wsel = '0; wdat = '0; ma = '0; mwd = '0;
    case (ins[15:11])
      5'b00000: begin hl = 1; npc = m_pc; end
      5'b00001: ;
      5'b01000: begin we = 1; wsel = ins[7:5]; wdat = a + s5; end
      5'b10000: begin st = 1; ma = a + s5; mwd = b; end
      5'b10001: begin re = 1; ma = a + s5; we = 1; wsel = ins[7:5]; wdat = dmem[a + s5]; end
      5'b11011: begin
        we = 1; wsel = ins[4:2];
        case (ins[1:0])
          2'd0: wdat = a + b;
          2'd1: wdat = a - b;
          2'd2: wdat = a ^ b;
          default: wdat = a & ~b;
        endcase
      end
      5'b11000: begin we = 1; wsel = ins[10:8]; wdat = s8; end
      5'b01100: if (a == 16'd0) npc = m_pc + 16'd2 + s8;
      5'b01101: if (a != 16'd0) npc = m_pc + 16'd2 + s8;
      5'b00100: npc = m_pc + 16'd2 + s11;
      default: und = 1;
    endcase
`ifdef PROC_ERR_EN
    exp_err = und;
`else
    exp_err = 1'b0;
`endif
    chk("imem_addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("inst", inst, ins);
    chk("cycle_count", cycle_count, m_cycle);
    chk("reg_we", reg_we, we);
    chk("reg_wsel", reg_wsel, wsel);
    chk("reg_wdata", reg_wdata, wdat);
    chk("mem_re", mem_re, re);
    chk("mem_we", mem_we, st);
    chk("mem_addr", mem_addr, ma);
    chk("mem_wdata", mem_wdata, mwd);
    chk("halt", halt, hl);
    chk("err", err, exp_err);
    if (we) m_r[wsel] = wdat;
    if (st) dmem[ma] = mwd;
    m_pc    = npc;
    m_cycle = m_cycle + 32'd1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      check_cycle();
    end
  endtask

  // Assert reset asynchronously between edges, check the forced state at once,
  // then release it between edges so the next rising edge is the first fetch.
  task automatic reset_dut(input string tag);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk({tag, "_pc"}, pc, 16'd0);
    chk({tag, "_cycle"}, cycle_count, 32'd0);
    chk({tag, "_reg_we"}, reg_we, 1'b0);
    chk({tag, "_mem_we"}, mem_we, 1'b0);
    chk({tag, "_mem_re"}, mem_re, 1'b0);
    chk({tag, "_halt"}, halt, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 32768; i++) imem[i] = 16'h0800;
  endtask

  function automatic logic [15:0] rand_inst();
    int unsigned k;
    logic [4:0]  op;
    logic [10:0] low;
    k   = $urandom_range(0, 63);
    low = 11'($urandom);
    if (k == 0) op = 5'b00000;
    else begin
      case (k % 11)
        0:  op = 5'b00001;
        1:  op = 5'b01000;
        2:  op = 5'b10000;
        3:  op = 5'b10001;
        4:  op = 5'b11011;
        5:  op = 5'b11000;
        6:  op = 5'b01100;
        7:  op = 5'b01101;
        8:  op = 5'b00100;
        9:  op = 5'b11111;
        default: op = 5'b00010;
      endcase
    end
    return {op, low};
  endfunction

  initial begin
    for (int i = 0; i < 65536; i++) dmem[i] = 16'($urandom);

    // Program 1: LBI R1,5 / LBI R2,3 / ADD R3=R1+R2 / HALT (imem[0] is LBI
    // during reset, so reg_we gating is exercised by the reset check).
    fill_nop();
    imem[0] = 16'hC105;
    imem[1] = 16'hC203;
    imem[2] = 16'hD94C;
    imem[3] = 16'h0000;
    reset_dut("rst0");
    run(8);
    chk("p1_halt_pc", pc, 16'h0006);
    chk("p1_halt", halt, 1'b1);

    // Program 2: negative immediates, SUB underflow, store/load, branches.
    fill_nop();
    imem[0] = 16'h403F;  // ADDI R1 = R0 + (-1)
    imem[1] = 16'hC401;  // LBI R4,1
    imem[2] = 16'hD895;  // SUB R5 = R0 - R4
    imem[3] = 16'hC120;  // LBI R1,0x20
    imem[4] = 16'hC234;  // LBI R2,0x34
    imem[5] = 16'h8142;  // ST R2 -> [R1+2]
    imem[6] = 16'h8962;  // LD R3 <- [R1+2]
    imem[7] = 16'h6810;  // BNEZ R0 (not taken)
    imem[8] = 16'h60FE;  // BEQZ R0,-2 at 0x0010 (spins)
    reset_dut("rst1");
    run(14);
    chk("p2_spin_pc", pc, 16'h0010);

    // Program 3: jump forward, undefined opcode, jump to 0xFFFE, PC wrap.
    fill_nop();
    imem[0]     = 16'h2004;  // J +4 -> 0x0006
    imem[3]     = 16'hF8FF;  // opcode 11111
    imem[4]     = 16'h27F4;  // J -12 -> 0xFFFE
    imem[32767] = 16'h0800;  // NOP at 0xFFFE, wraps to 0
    reset_dut("rst2");
    run(12);

    // Random programs with mid-run resets.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 32768; i++) imem[i] = rand_inst();
      reset_dut("rst_rand");
      run(400);
      reset_dut("rst_mid");
      run(400);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
